// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the branch predictor
//
// Contents:
//   bp_state_t     clear-sweep FSM states (BP_IDLE, BP_CLEAR)
//   bp_entry_t     one table entry: valid, tag, target, direction counter
//   bp_weak_taken  weakly-taken counter value for a given counter width
//
// The entry fields are sized for the widest supported configuration
// (ADDR_W up to 32, CNT_W up to 4). The predictor zero-extends into them and
// narrows back out, so unused upper bits are constant zero.
package bp_pkg;

    localparam int BP_MAX_ADDR_W = 32;
    localparam int BP_MAX_CNT_W  = 4;

    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_CLEAR = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                     valid;
        logic [BP_MAX_ADDR_W-1:0] tag;
        logic [BP_MAX_ADDR_W-1:0] target;
        logic [BP_MAX_CNT_W-1:0]  counter;
    } bp_entry_t;

    // Only the MSB is set, which is the lowest counter value predicting taken.
    function automatic logic [BP_MAX_CNT_W-1:0] bp_weak_taken(input int cnt_w);
        bp_weak_taken = BP_MAX_CNT_W'(1) << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational saturating increment/decrement
//
// Ports:
//   cnt       current counter value
//   up        1: increment (saturate at all-ones), 0: decrement (saturate at 0)
//   cnt_next  updated counter value
module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             up,
    output logic [CNT_W-1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (up) begin
            if (cnt != '1) begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            if (cnt != '0) begin
                cnt_next = cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
//
// Looked up combinationally with the IF-stage PC; trained from ID once the
// branch resolves. A clear request sweeps the table one entry per cycle.
//
// Optional feature macro: BP_STATS_EN (update / mispredict statistics counters).
// Without it the stat outputs are tied to zero and no counter registers exist.
//
// Ports:
//   clk, reset_in                  clock, asynchronous active-low reset
//   pc_in                          lookup PC
//   pred_hit_out / pred_taken_out  lookup result
//   pred_next_pc_out               predicted next PC (target or pc_in+4)
//   upd_valid_in, upd_pc_in,
//   upd_taken_in, upd_target_in    resolved-branch training port
//   upd_mispredict_in              mispredict flag, statistics only
//   clear_in                       pulse: invalidate the whole table
//   busy_out                       clear sweep in progress
//   stat_upd_out, stat_miss_out    accepted updates / accepted mispredicts
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pred_hit_out,
    output logic              pred_taken_out,
    output logic [ADDR_W-1:0] pred_next_pc_out,
    input  logic              upd_valid_in,
    input  logic [ADDR_W-1:0] upd_pc_in,
    input  logic              upd_taken_in,
    input  logic [ADDR_W-1:0] upd_target_in,
    input  logic              upd_mispredict_in,
    input  logic              clear_in,
    output logic              busy_out,
    output logic [31:0]       stat_upd_out,
    output logic [31:0]       stat_miss_out
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    bp_entry_t        table_q [ENTRIES];
    bp_state_t        state_q;
    bp_state_t        state_d;
    logic [IDX_W-1:0] sweep_q;
    logic             busy;
    logic             clear_start;

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [CNT_W-1:0] lk_cnt;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx = pc_in[IDX_W+1:2];
    assign lk_tag = pc_in[ADDR_W-1:IDX_W+2];
    assign lk_cnt = CNT_W'(table_q[lk_idx].counter);
    assign lk_hit = !busy && table_q[lk_idx].valid
                    && (table_q[lk_idx].tag == BP_MAX_ADDR_W'(lk_tag));
    // Counter MSB set is the same as being at or above the weakly-taken value.
    assign lk_taken = lk_hit && (lk_cnt >= CNT_W'(bp_weak_taken(CNT_W)));

    assign pred_hit_out     = lk_hit;
    assign pred_taken_out   = lk_taken;
    assign pred_next_pc_out = lk_taken ? ADDR_W'(table_q[lk_idx].target)
                                       : pc_in + ADDR_W'(4);

    // ---------------- update ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] up_cnt_next;
    logic             up_hit;
    logic             up_accept;
    logic             upd_pc_lsb_unused;

    assign up_idx    = upd_pc_in[IDX_W+1:2];
    assign up_tag    = upd_pc_in[ADDR_W-1:IDX_W+2];
    assign up_cnt    = CNT_W'(table_q[up_idx].counter);
    assign up_hit    = table_q[up_idx].valid
                       && (table_q[up_idx].tag == BP_MAX_ADDR_W'(up_tag));
    assign up_accept = upd_valid_in && !busy;
    assign upd_pc_lsb_unused = ^upd_pc_in[1:0];

    bp_sat_counter #(.CNT_W(CNT_W)) u_sat (
        .cnt      (up_cnt),
        .up       (upd_taken_in),
        .cnt_next (up_cnt_next)
    );

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (busy) begin
            table_q[sweep_q].valid <= 1'b0;
        end else if (up_accept) begin
            if (up_hit) begin
                table_q[up_idx].counter <= BP_MAX_CNT_W'(up_cnt_next);
                if (upd_taken_in) begin
                    table_q[up_idx].target <= BP_MAX_ADDR_W'(upd_target_in);
                end
            end else if (upd_taken_in) begin
                // Allocation replaces whatever aliased entry sits at this index.
                table_q[up_idx] <= '{valid:   1'b1,
                                     tag:     BP_MAX_ADDR_W'(up_tag),
                                     target:  BP_MAX_ADDR_W'(upd_target_in),
                                     counter: bp_weak_taken(CNT_W)};
            end
        end
    end

    // ---------------- clear FSM ----------------
    assign clear_start = (state_q == BP_IDLE) && clear_in;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= BP_IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == BP_IDLE) begin
                sweep_q <= '0;
            end else begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BP_IDLE:  if (clear_in) state_d = BP_CLEAR;
            BP_CLEAR: if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = BP_IDLE;
            default:  state_d = BP_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BP_CLEAR);
    end

    assign busy_out = busy;

    // ---------------- statistics ----------------
`ifdef BP_STATS_EN
    logic [31:0] stat_upd_q;
    logic [31:0] stat_miss_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            stat_upd_q  <= '0;
            stat_miss_q <= '0;
        end else if (clear_start) begin
            stat_upd_q  <= '0;
            stat_miss_q <= '0;
        end else if (up_accept) begin
            stat_upd_q <= stat_upd_q + 32'd1;
            if (upd_mispredict_in) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end

    assign stat_upd_out  = stat_upd_q;
    assign stat_miss_out = stat_miss_q;
`else
    logic stats_unused;
    assign stats_unused  = upd_mispredict_in ^ clear_start;
    assign stat_upd_out  = '0;
    assign stat_miss_out = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

`ifdef BP_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    localparam logic [31:0] PC_A  = 32'h0040_0010;
    localparam logic [31:0] PC_B  = 32'h0040_0110;
    localparam logic [31:0] PC_C  = 32'h0040_0020;
    localparam logic [31:0] PC_D  = 32'h0040_0040;
    localparam logic [31:0] PC_E  = 32'h0040_00F0;
    localparam logic [31:0] TGT_1 = 32'h0040_0100;
    localparam logic [31:0] TGT_2 = 32'h0040_0200;
    localparam logic [31:0] TGT_3 = 32'h0040_1000;
    localparam logic [31:0] JUNK  = 32'h0BAD_0000;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [31:0] pc_in;
    logic        pred_hit_out;
    logic        pred_taken_out;
    logic [31:0] pred_next_pc_out;
    logic        upd_valid_in;
    logic [31:0] upd_pc_in;
    logic        upd_taken_in;
    logic [31:0] upd_target_in;
    logic        upd_mispredict_in;
    logic        clear_in;
    logic        busy_out;
    logic [31:0] stat_upd_out;
    logic [31:0] stat_miss_out;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .ADDR_W(32), .CNT_W(2)) dut (
        .clk               (clk),
        .reset_in          (reset_in),
        .pc_in             (pc_in),
        .pred_hit_out      (pred_hit_out),
        .pred_taken_out    (pred_taken_out),
        .pred_next_pc_out  (pred_next_pc_out),
        .upd_valid_in      (upd_valid_in),
        .upd_pc_in         (upd_pc_in),
        .upd_taken_in      (upd_taken_in),
        .upd_target_in     (upd_target_in),
        .upd_mispredict_in (upd_mispredict_in),
        .clear_in          (clear_in),
        .busy_out          (busy_out),
        .stat_upd_out      (stat_upd_out),
        .stat_miss_out     (stat_miss_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        umis;
        logic [31:0] lpc;
        logic        hit;
        logic        tkn;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic umis,
                                input logic [31:0] lpc, input logic hit, input logic tkn,
                                input logic [31:0] nxt);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.umis = umis;
        v.lpc = lpc; v.hit = hit; v.tkn = tkn; v.nxt = nxt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_upd();
        upd_valid_in      = 1'b0;
        upd_pc_in         = '0;
        upd_taken_in      = 1'b0;
        upd_target_in     = '0;
        upd_mispredict_in = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic mis);
        upd_valid_in      = 1'b1;
        upd_pc_in         = pc;
        upd_taken_in      = taken;
        upd_target_in     = tgt;
        upd_mispredict_in = mis;
        tick();
        idle_upd();
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic hit);
        pc_in = pc;
        #1;
        chk(name, {31'd0, pred_hit_out}, {31'd0, hit});
    endtask

    initial begin
        int exp_upd;
        int exp_miss;

        // Lookup table: each lookup sees the state before that row's update.
        vecs.push_back(mk(0, 0,     0, 0,     0, PC_A, 0, 0, 32'h0040_0014));
        vecs.push_back(mk(1, PC_A,  1, TGT_1, 0, PC_A, 0, 0, 32'h0040_0014)); // alloc -> 10
        vecs.push_back(mk(1, PC_A,  0, JUNK,  1, PC_A, 1, 1, TGT_1));         // -> 01
        vecs.push_back(mk(1, PC_A,  0, 0,     0, PC_A, 1, 0, 32'h0040_0014)); // -> 00
        vecs.push_back(mk(1, PC_A,  0, 0,     1, PC_A, 1, 0, 32'h0040_0014)); // stays 00
        vecs.push_back(mk(1, PC_A,  1, TGT_1, 0, PC_A, 1, 0, 32'h0040_0014)); // -> 01
        vecs.push_back(mk(1, PC_A,  1, TGT_1, 0, PC_A, 1, 0, 32'h0040_0014)); // -> 10
        vecs.push_back(mk(1, PC_A,  1, TGT_1, 1, PC_A, 1, 1, TGT_1));         // -> 11
        vecs.push_back(mk(1, PC_A,  1, TGT_2, 0, PC_A, 1, 1, TGT_1));         // stays 11, tgt 2
        vecs.push_back(mk(1, PC_A,  0, JUNK,  0, PC_A, 1, 1, TGT_2));         // -> 10
        vecs.push_back(mk(1, PC_A,  0, 0,     0, PC_A, 1, 1, TGT_2));         // -> 01
        vecs.push_back(mk(0, 0,     0, 0,     0, PC_A, 1, 0, 32'h0040_0014));
        vecs.push_back(mk(1, PC_B,  1, TGT_3, 1, PC_B, 0, 0, 32'h0040_0114)); // replaces A
        vecs.push_back(mk(0, 0,     0, 0,     0, PC_A, 0, 0, 32'h0040_0014));
        vecs.push_back(mk(0, 0,     0, 0,     0, PC_B, 1, 1, TGT_3));
        vecs.push_back(mk(1, PC_C,  0, JUNK,  0, PC_C, 0, 0, 32'h0040_0024)); // no alloc
        vecs.push_back(mk(0, 0,     0, 0,     0, PC_C, 0, 0, 32'h0040_0024));
        vecs.push_back(mk(0, 0,     0, 0,     0, 32'hFFFF_FFFC, 0, 0, 32'h0000_0000));

        reset_in = 1'b1;
        pc_in    = PC_A;
        clear_in = 1'b0;
        idle_upd();
        #1 reset_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_stat_upd", stat_upd_out, 32'd0);
        chk("rst_stat_miss", stat_miss_out, 32'd0);
        chk("rst_hit", {31'd0, pred_hit_out}, 32'd0);
        chk("rst_next", pred_next_pc_out, 32'h0040_0014);
        reset_in = 1'b1;
        tick();

        exp_upd  = 0;
        exp_miss = 0;
        foreach (vecs[i]) begin
            upd_valid_in      = vecs[i].uv;
            upd_pc_in         = vecs[i].upc;
            upd_taken_in      = vecs[i].ut;
            upd_target_in     = vecs[i].utgt;
            upd_mispredict_in = vecs[i].umis;
            pc_in             = vecs[i].lpc;
            #1;
            chk($sformatf("v%0d_hit", i), {31'd0, pred_hit_out}, {31'd0, vecs[i].hit});
            chk($sformatf("v%0d_taken", i), {31'd0, pred_taken_out}, {31'd0, vecs[i].tkn});
            chk($sformatf("v%0d_next", i), pred_next_pc_out, vecs[i].nxt);
            if (vecs[i].uv) begin
                exp_upd++;
                if (vecs[i].umis) exp_miss++;
            end
            tick();
        end
        idle_upd();
        chk("tbl_stat_upd", stat_upd_out, STATS_EN ? 32'(exp_upd) : 32'd0);
        chk("tbl_stat_miss", stat_miss_out, STATS_EN ? 32'(exp_miss) : 32'd0);

        // Clear sweep with B (idx 4) and D (idx 16) populated.
        do_upd(PC_D, 1'b1, 32'h0040_0800, 1'b0);
        look("pre_clr_d", PC_D, 1'b1);
        pc_in    = PC_B;
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("clr_busy%0d", i), {31'd0, busy_out}, 32'd1);
            chk($sformatf("clr_hit%0d", i), {31'd0, pred_hit_out}, 32'd0);
            if (i == 8) clear_in = 1'b1;
            if (i == 9) clear_in = 1'b0;
            if (i >= 60) begin
                upd_valid_in  = 1'b1;
                upd_pc_in     = PC_A;
                upd_taken_in  = 1'b1;
                upd_target_in = 32'h0040_0300;
            end
            tick();
        end
        idle_upd();
        chk("clr_done_busy", {31'd0, busy_out}, 32'd0);
        chk("clr_stat_upd", stat_upd_out, 32'd0);
        chk("clr_stat_miss", stat_miss_out, 32'd0);
        look("clr_a", PC_A, 1'b0);
        look("clr_b", PC_B, 1'b0);
        look("clr_d", PC_D, 1'b0);

        // Reset in the middle of a sweep; E (idx 60) is not yet swept.
        do_upd(PC_E, 1'b1, TGT_2, 1'b0);
        look("pre_rst_e", PC_E, 1'b1);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        repeat (10) tick();
        chk("mid_busy", {31'd0, busy_out}, 32'd1);
        reset_in = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy_out}, 32'd0);
        tick();
        reset_in = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy_out}, 32'd0);
        look("post_rst_e", PC_E, 1'b0);

        // Statistics: 10 accepted updates, 3 flagged as mispredicts.
        for (int i = 0; i < 10; i++) begin
            do_upd(PC_A + 32'(i * 4), i[0], TGT_1, (i == 1 || i == 4 || i == 7));
        end
        chk("stat_upd10", stat_upd_out, STATS_EN ? 32'd10 : 32'd0);
        chk("stat_miss3", stat_miss_out, STATS_EN ? 32'd3 : 32'd0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("stat_clr_busy", {31'd0, busy_out}, 32'd1);
        chk("stat_clr_upd", stat_upd_out, 32'd0);
        chk("stat_clr_miss", stat_miss_out, 32'd0);
        repeat (64) tick();
        chk("stat_clr_done", {31'd0, busy_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
